sync_fifo_ctrl: RTL



---
 rtl/sync_fifo_pkg.sv | 19 +
 rtl/sync_fifo_ctrl_if.sv | 38 +++
 rtl/sync_fifo_mem.sv | 30 +++
 rtl/sync_fifo_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the single-clock FIFO.
// Contents: default widths, DEPTH helper function, pointer/address typedefs.
// Optional feature macro used by sync_fifo_ctrl: SYNC_FIFO_FWFT_EN.
package sync_fifo_pkg;

    localparam int unsigned DSIZE_DEF = 8;
    localparam int unsigned ASIZE_DEF = 4;

    function automatic int unsigned fifo_depth(input int unsigned asize);
        return 32'd1 << asize;
    endfunction

    localparam int unsigned DEPTH_DEF = fifo_depth(ASIZE_DEF);

    // Pointers carry one extra wrap bit above the memory address.
    typedef logic [ASIZE_DEF:0]   ptr_t;
    typedef logic [ASIZE_DEF-1:0] addr_t;

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Producer/consumer side bundle of the single-clock FIFO.
// master: drives clr, wdata, winc, rinc, afull_th, aempty_th; observes status.
// slave : the FIFO controller; drives rdata, wfull, rempty, walmost_full,
//         ralmost_empty, count, wovf, rudf.
interface sync_fifo_ctrl_if
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DSIZE = DSIZE_DEF,
    parameter int unsigned ASIZE = ASIZE_DEF
);

    logic             clr;
    logic [DSIZE-1:0] wdata;
    logic             winc;
    logic             rinc;
    logic [ASIZE:0]   afull_th;
    logic [ASIZE:0]   aempty_th;

    logic [DSIZE-1:0] rdata;
    logic             wfull;
    logic             rempty;
    logic             walmost_full;
    logic             ralmost_empty;
    logic [ASIZE:0]   count;
    logic             wovf;
    logic             rudf;

    modport master (
        output clr, wdata, winc, rinc, afull_th, aempty_th,
        input  rdata, wfull, rempty, walmost_full, ralmost_empty, count, wovf, rudf
    );

    modport slave (
        input  clr, wdata, winc, rinc, afull_th, aempty_th,
        output rdata, wfull, rempty, walmost_full, ralmost_empty, count, wovf, rudf
    );

endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x DSIZE dual-port storage for the single-clock FIFO.
// Synchronous write, asynchronous read, contents never reset.
// Ports: clk, we_i, waddr_i, wdata_i (write side); raddr_i, rdata_o (read side).
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DSIZE = DSIZE_DEF,
    parameter int unsigned ASIZE = ASIZE_DEF
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [ASIZE-1:0] waddr_i,
    input  logic [DSIZE-1:0] wdata_i,
    input  logic [ASIZE-1:0] raddr_i,
    output logic [DSIZE-1:0] rdata_o
);

    localparam int unsigned DEPTH = fifo_depth(ASIZE);

    logic [DSIZE-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: binary wrap-bit pointers, occupancy count,
// programmable almost-full/almost-empty flags, sticky overflow/underflow,
// synchronous clear. All status is decoded from registered state.
// Ports: clk, rst_n (async, active-low), bus (sync_fifo_ctrl_if.slave).
// Macro SYNC_FIFO_FWFT_EN: first-word fall-through output register;
// undefined gives standard mode with 1-cycle read latency.
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DSIZE = DSIZE_DEF,
    parameter int unsigned ASIZE = ASIZE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    sync_fifo_ctrl_if.slave  bus
);

    localparam logic [ASIZE:0] PTR_ONE  = {{ASIZE{1'b0}}, 1'b1};
    localparam logic [ASIZE:0] FULL_CNT = {1'b1, {ASIZE{1'b0}}};

    logic [ASIZE:0]   wptr_q, wptr_d;
    logic [ASIZE:0]   rptr_q, rptr_d;
    logic [DSIZE-1:0] rdata_q, rdata_d;
    logic             wovf_q, wovf_d;
    logic             rudf_q, rudf_d;

    logic [DSIZE-1:0] mem_rdata;
    logic [ASIZE:0]   mem_cnt;
    logic [ASIZE:0]   count;
    logic             mem_empty;
    logic             wfull;
    logic             rempty;
    logic             wr_en;
    logic             mem_rd;

    assign mem_cnt   = wptr_q - rptr_q;
    assign mem_empty = (wptr_q == rptr_q);

`ifdef SYNC_FIFO_FWFT_EN
    logic ov_q, ov_d;
    logic pop;

    // Head word lives in rdata_q; memory holds only the words behind it.
    assign count  = mem_cnt + {{ASIZE{1'b0}}, ov_q};
    assign wfull  = (count == FULL_CNT);
    assign rempty = !ov_q;
    assign pop    = bus.rinc && ov_q && !bus.clr;
    // Refill the output register whenever it is free or being popped.
    assign mem_rd = (!ov_q || pop) && !mem_empty && !bus.clr;

    always_comb begin
        ov_d = ov_q;
        if (bus.clr) begin
            ov_d = 1'b0;
        end else if (mem_rd) begin
            ov_d = 1'b1;
        end else if (pop) begin
            ov_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_q <= 1'b0;
        end else begin
            ov_q <= ov_d;
        end
    end
`else
    assign count  = mem_cnt;
    assign wfull  = (wptr_q[ASIZE] != rptr_q[ASIZE]) &&
                    (wptr_q[ASIZE-1:0] == rptr_q[ASIZE-1:0]);
    assign rempty = mem_empty;
    assign mem_rd = bus.rinc && !rempty && !bus.clr;
`endif

    assign wr_en = bus.winc && !wfull && !bus.clr;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        rdata_d = rdata_q;
        wovf_d  = wovf_q;
        rudf_d  = rudf_q;
        if (bus.clr) begin
            wptr_d = '0;
            rptr_d = '0;
            wovf_d = 1'b0;
            rudf_d = 1'b0;
        end else begin
            if (wr_en) begin
                wptr_d = wptr_q + PTR_ONE;
            end
            if (mem_rd) begin
                rptr_d  = rptr_q + PTR_ONE;
                rdata_d = mem_rdata;
            end
            if (bus.winc && wfull) begin
                wovf_d = 1'b1;
            end
            if (bus.rinc && rempty) begin
                rudf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            rdata_q <= '0;
            wovf_q  <= 1'b0;
            rudf_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            rdata_q <= rdata_d;
            wovf_q  <= wovf_d;
            rudf_q  <= rudf_d;
        end
    end

    sync_fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wptr_q[ASIZE-1:0]),
        .wdata_i (bus.wdata),
        .raddr_i (rptr_q[ASIZE-1:0]),
        .rdata_o (mem_rdata)
    );

    assign bus.rdata         = rdata_q;
    assign bus.wfull         = wfull;
    assign bus.rempty        = rempty;
    assign bus.count         = count;
    assign bus.wovf          = wovf_q;
    assign bus.rudf          = rudf_q;
    assign bus.walmost_full  = (bus.afull_th != '0) && (count >= bus.afull_th);
    assign bus.ralmost_empty = (count <= bus.aempty_th);

endmodule
